// File: rtl/seg7_time_reader.sv
// rtl/seg7_time_reader.sv - recovers and checks HH:MM:SS from six 7-segment digit buses
// Optional sequence check enabled by defining SEG7_READER_SEQ_CHECK_EN.
module seg7_time_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_hh1,
  input  logic [6:0] seg_hh2,
  input  logic [6:0] seg_mm1,
  input  logic [6:0] seg_mm2,
  input  logic [6:0] seg_ss1,
  input  logic [6:0] seg_ss2,
  output logic       time_valid,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       decode_err,
  output logic       seq_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_e;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [41:0] seg_in, s_q, cap_q, lat_q, lat_d;
  logic        chg_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        apply;
  logic [7:0]  hh_q, mm_q, ss_q, err_q;
  logic        tv_q, derr_q, serr_q;

  assign seg_in = {seg_hh1, seg_hh2, seg_mm1, seg_mm2, seg_ss1, seg_ss2};

  // Returns {legal, bcd value}.
  function automatic logic [4:0] dec_digit(input logic [6:0] p);
    case (p)
      7'h3F: dec_digit = 5'h10;
      7'h06: dec_digit = 5'h11;
      7'h5B: dec_digit = 5'h12;
      7'h4F: dec_digit = 5'h13;
      7'h66: dec_digit = 5'h14;
      7'h6D: dec_digit = 5'h15;
      7'h7D: dec_digit = 5'h16;
      7'h07: dec_digit = 5'h17;
      7'h7F: dec_digit = 5'h18;
      7'h6F: dec_digit = 5'h19;
      default: dec_digit = 5'h00;
    endcase
  endfunction

  logic [4:0] d_h1, d_h2, d_m1, d_m2, d_s1, d_s2;
  logic [7:0] rd_hh, rd_mm, rd_ss;
  logic       good, seq_fail;

  assign d_h1  = dec_digit(lat_q[41:35]);
  assign d_h2  = dec_digit(lat_q[34:28]);
  assign d_m1  = dec_digit(lat_q[27:21]);
  assign d_m2  = dec_digit(lat_q[20:14]);
  assign d_s1  = dec_digit(lat_q[13:7]);
  assign d_s2  = dec_digit(lat_q[6:0]);
  assign rd_hh = {d_h1[3:0], d_h2[3:0]};
  assign rd_mm = {d_m1[3:0], d_m2[3:0]};
  assign rd_ss = {d_s1[3:0], d_s2[3:0]};
  // Digits are valid BCD once legal, so packed BCD compares like binary.
  assign good  = d_h1[4] & d_h2[4] & d_m1[4] & d_m2[4] & d_s1[4] & d_s2[4] &
                 (rd_hh <= 8'h23) & (rd_mm <= 8'h59) & (rd_ss <= 8'h59);

`ifdef SEG7_READER_SEQ_CHECK_EN
  function automatic logic [23:0] bcd_inc_time(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          if (m1 != 4'd5) m1 = m1 + 4'd1;
          else begin
            m1 = 4'd0;
            if ({h1, h0} == 8'h23) {h1, h0} = 8'h00;
            else if (h0 != 4'd9) h0 = h0 + 4'd1;
            else begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    bcd_inc_time = {h1, h0, m1, m0, s1, s0};
  endfunction

  logic        ref_valid_q;
  logic [23:0] exp_t;

  assign exp_t    = bcd_inc_time({hh_q, mm_q, ss_q});
  assign seq_fail = ref_valid_q & good & ({rd_hh, rd_mm, rd_ss} != exp_t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ref_valid_q <= 1'b0;
    else if (apply) ref_valid_q <= good;
  end
`else
  assign seq_fail = 1'b0;
`endif

  // chg_q flags that s_q took a different value on the previous edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    apply   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_q != cap_q) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        if (chg_q) cnt_d = 8'd0;
        else if (cnt_q == CNT_LAST) begin
          lat_d   = s_q;
          state_d = CHECK;
        end else cnt_d = cnt_q + 8'd1;
      end
      CHECK: begin
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      chg_q   <= 1'b0;
      cap_q   <= '0;
      lat_q   <= '0;
      cnt_q   <= 8'd0;
      tv_q    <= 1'b0;
      derr_q  <= 1'b0;
      serr_q  <= 1'b0;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      s_q     <= seg_in;
      chg_q   <= (seg_in != s_q);
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      tv_q    <= apply;
      derr_q  <= apply & ~good;
      serr_q  <= apply & seq_fail;
      if (apply) cap_q <= lat_q;
      if (apply && good) begin
        hh_q <= rd_hh;
        mm_q <= rd_mm;
        ss_q <= rd_ss;
      end
      if (apply && (!good || seq_fail) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign time_valid = tv_q;
  assign decode_err = derr_q;
  assign seq_err    = serr_q;
  assign hh         = hh_q;
  assign mm         = mm_q;
  assign ss         = ss_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_seg7_time_reader.sv
// tb/tb_seg7_time_reader.sv - self-checking bench for seg7_time_reader
module tb_seg7_time_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_hh1, seg_hh2, seg_mm1, seg_mm2, seg_ss1, seg_ss2;
  logic       time_valid, decode_err, seq_err;
  logic [7:0] hh, mm, ss, err_count;

  always #5 clk = ~clk;

  seg7_time_reader dut (
    .clk(clk), .rst_n(rst_n),
    .seg_hh1(seg_hh1), .seg_hh2(seg_hh2), .seg_mm1(seg_mm1),
    .seg_mm2(seg_mm2), .seg_ss1(seg_ss1), .seg_ss2(seg_ss2),
    .time_valid(time_valid), .hh(hh), .mm(mm), .ss(ss),
    .decode_err(decode_err), .seq_err(seq_err), .err_count(err_count)
  );

`ifdef SEG7_READER_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int compared = 0;
  int mismatched = 0;

  // Reference model state: readings as plain seconds-of-day.
  bit          m_ref;
  int          m_prev;
  logic [7:0]  m_hh, m_mm, m_ss, m_err;
  logic        m_dec, m_seq;
  logic [41:0] m_cap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dig(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [41:0] mk(input int h, input int m, input int s);
    return {seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10],
            seg_tab[m % 10], seg_tab[s / 10], seg_tab[s % 10]};
  endfunction

  task automatic model_reset();
    m_ref = 0; m_prev = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_err = 0;
    m_dec = 0; m_seq = 0; m_cap = '0;
  endtask

  task automatic model_accept(input logic [41:0] pat);
    int d [6];
    bit legal;
    int h, m, s, secs;
    legal = 1;
    for (int k = 0; k < 6; k++) begin
      d[k] = dig(pat[41 - 7 * k -: 7]);
      if (d[k] < 0) legal = 0;
    end
    h = d[0] * 10 + d[1];
    m = d[2] * 10 + d[3];
    s = d[4] * 10 + d[5];
    if (legal && (h > 23 || m > 59 || s > 59)) legal = 0;
    if (!legal) begin
      m_dec = 1; m_seq = 0; m_ref = 0;
    end else begin
      secs  = h * 3600 + m * 60 + s;
      m_dec = 0;
      m_seq = SEQ_EN && m_ref && (secs != (m_prev + 1) % 86400);
      m_prev = secs; m_ref = 1;
      m_hh = 8'(d[0] * 16 + d[1]);
      m_mm = 8'(d[2] * 16 + d[3]);
      m_ss = 8'(d[4] * 16 + d[5]);
    end
    if ((m_dec || m_seq) && m_err != 8'hFF) m_err = m_err + 8'd1;
    m_cap = pat;
  endtask

  task automatic drive(input logic [41:0] pat);
    @(negedge clk);
    {seg_hh1, seg_hh2, seg_mm1, seg_mm2, seg_ss1, seg_ss2} = pat;
  endtask

  task automatic wait_and_check(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (time_valid) begin n = i; break; end
    end
    chk({tag, "_latency"}, n, 7);
    chk({tag, "_decode_err"}, decode_err, m_dec);
    chk({tag, "_seq_err"}, seq_err, m_seq);
    chk({tag, "_hh"}, hh, m_hh);
    chk({tag, "_mm"}, mm, m_mm);
    chk({tag, "_ss"}, ss, m_ss);
    chk({tag, "_err_count"}, err_count, m_err);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {time_valid, decode_err, seq_err}, 3'b000);
  endtask

  task automatic reading(input logic [41:0] pat, input string tag);
    drive(pat);
    model_accept(pat);
    wait_and_check(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tv"}, time_valid, 1'b0);
    chk({tag, "_derr"}, decode_err, 1'b0);
    chk({tag, "_serr"}, seq_err, 1'b0);
    chk({tag, "_hh"}, hh, 8'h00);
    chk({tag, "_mm"}, mm, 8'h00);
    chk({tag, "_ss"}, ss, 8'h00);
    chk({tag, "_err"}, err_count, 8'h00);
  endtask

  initial begin
    logic [41:0] pat;
    int          cnt_v, mode, h, m, s, slot;
    logic [6:0]  bad;

    rst_n = 1'b0;
    {seg_hh1, seg_hh2, seg_mm1, seg_mm2, seg_ss1, seg_ss2} = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    cnt_v = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (time_valid) cnt_v++;
    end
    chk("blank_no_reading", cnt_v, 0);

    reading(mk(12, 34, 56), "t123456");
    reading(mk(12, 34, 57), "t123457");
    reading(mk(12, 34, 59), "t123459");
    chk("ss_after_skip", ss, 8'h59);
    chk("err_after_skip", err_count, SEQ_EN ? 8'd1 : 8'd0);
    reading(mk(23, 59, 59), "t235959");
    reading(mk(0, 0, 0), "t000000");
    chk("wrap_hms", {hh, mm, ss}, 24'h000000);
    reading(mk(0, 0, 1), "t000001");

    // ss2 bounces between 1 and 2 before settling on 2.
    cnt_v = 0;
    for (int i = 0; i < 5; i++) begin
      drive(mk(0, 0, (i % 2 == 0) ? 1 : 2));
      for (int j = 0; j < 2; j++) begin
        if (j > 0) @(negedge clk);
        if (time_valid) cnt_v++;
      end
    end
    chk("toggle_no_reading", cnt_v, 0);
    reading(mk(0, 0, 2), "toggle_final");

    pat = mk(0, 0, 3);
    pat[27:21] = 7'h7E;
    reading(pat, "bad_mm1");
    reading(mk(24, 0, 0), "range_24h");
    reading(mk(10, 0, 0), "after_bad");

    pat = mk(5, 6, 7);
    drive(pat);
    cnt_v = 0;
    repeat (3) begin
      @(negedge clk);
      if (time_valid) cnt_v++;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_settle_reset");
    repeat (2) begin
      @(negedge clk);
      if (time_valid) cnt_v++;
    end
    chk("mid_settle_no_reading", cnt_v, 0);
    model_reset();
    rst_n = 1'b1;
    model_accept(pat);
    wait_and_check("post_reset");

    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0 && m_ref) begin
        s = (m_prev + 1) % 86400;
        pat = mk(s / 3600, (s / 60) % 60, s % 60);
      end else begin
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 59);
        s = $urandom_range(0, 59);
        if (mode == 3) begin
          if ($urandom_range(0, 1) == 0) h = $urandom_range(24, 29);
          else m = $urandom_range(60, 99);
        end
        pat = mk(h, m, s);
        if (mode == 2) begin
          do bad = 7'($urandom_range(0, 127)); while (dig(bad) >= 0);
          slot = $urandom_range(0, 5);
          pat[41 - 7 * slot -: 7] = bad;
        end
      end
      if (pat != m_cap) reading(pat, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
